i2s_to_wb_rx: RTL and testbench
===============================

I2S_TO_WB_RX -- requirements
Module: i2s_to_wb_rx

Interface
REQ-001 The module SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 Port list (name direction width meaning), clock and reset first:
- wb_clk_i  in  1  system clock; all flops on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- i2s_enable  in  1  receiver enable; low holds the receiver idle.
- i2s_sck_i  in  1  I2S bit clock, asynchronous, sampled as data.
- i2s_ws_i  in  1  I2S word select (0 = left, 1 = right), asynchronous.
- i2s_sd_i  in  1  I2S serial data, MSB first, asynchronous.
- fifo_left_data  out  32  left word of the completed frame.
- fifo_right_data  out  32  right word of the completed frame.
- fifo_wr  out  1  one-cycle write strobe for both words.
- fifo_full  in  1  sink cannot accept a write.
- i2s_ws_edge  out  1  one-cycle pulse on each detected WS transition.
- rx_overflow  out  1  sticky flag: a frame was dropped because fifo_full was high.
REQ-003 wb_clk_i SHALL be at least 4x the i2s_sck_i frequency; slower ratios are out of scope.

Function
REQ-004 i2s_sck_i, i2s_ws_i and i2s_sd_i SHALL each pass through a 2-flop synchronizer, followed by one further delay stage on sck only.
REQ-005 An sck rise SHALL be detected as synchronized sck = 1 with delayed sck = 0. ws and sd SHALL be sampled in that same cycle (cycle T).
REQ-006 The state machine SHALL have four states: IDLE, SYNC, LEFT, RIGHT.
- IDLE -> SYNC when i2s_enable = 1.
- Any state -> IDLE when i2s_enable = 0.
- SYNC -> LEFT on the first sampled ws 1->0 transition; no data is captured in SYNC.
- LEFT -> RIGHT on a sampled ws 0->1 transition.
- RIGHT -> LEFT on a sampled ws 1->0 transition.
REQ-007 A WS transition SHALL be a sampled ws differing from the ws sampled at the previous sck rise. i2s_ws_edge SHALL pulse in cycle T+1 for every transition, in any non-IDLE state.
REQ-008 On each sck rise in LEFT or RIGHT, sd SHALL be written to shift bit (31 - bit_cnt) while bit_cnt < 32. bit_cnt SHALL saturate at 32, so bits beyond 32 are discarded.
REQ-009 I2S one-bit delay: at a WS transition, the sd sampled in cycle T SHALL be the final bit of the word of the old channel. The word SHALL then be committed, the shift register cleared, and bit_cnt reset to 0.
REQ-010 Words shorter than 32 bits SHALL be left-justified with zero fill. Example: a 16-bit word 0xA5C3 commits as 0xA5C30000.
REQ-011 A committed LEFT word SHALL be held internally and set left_valid. A committed RIGHT word SHALL end the frame.
REQ-012 At frame end with left_valid = 1:
- fifo_full = 0: fifo_left_data and fifo_right_data SHALL update and fifo_wr SHALL be 1 for exactly cycle T+1.
- fifo_full = 1: no write SHALL occur, rx_overflow SHALL set, and outputs SHALL hold their old values.
- In both cases left_valid SHALL clear.
REQ-013 A RIGHT word committed with left_valid = 0 SHALL be discarded silently.
REQ-014 fifo_full SHALL be evaluated only in the frame-end cycle. fifo_wr SHALL never be high for 2 consecutive cycles.
REQ-015 Deasserting i2s_enable mid-word SHALL abandon the partial word and left_valid, and SHALL clear rx_overflow. fifo_left_data and fifo_right_data SHALL hold.
REQ-016 A WS transition and a deasserting i2s_enable in the same cycle: disable SHALL win, with no commit and no fifo_wr.

Reset
REQ-017 On wb_rst_i = 1 the following SHALL clear:
- fifo_wr, i2s_ws_edge, rx_overflow = 0.
- fifo_left_data, fifo_right_data = 32'h0.
- state = IDLE, bit_cnt = 0, left_valid = 0.
- synchronizer and shift registers = 0.
REQ-018 Reset SHALL take priority over i2s_enable and over any in-flight frame. The first fifo_wr after reset SHALL require a full SYNC -> LEFT -> RIGHT -> LEFT sequence.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- 32-bit frame, left = 0x12345678, right = 0x9ABCDEF0, fifo_full = 0 -> one fifo_wr pulse with exactly those values, 1 cycle after the detected sck rise at the ws 1->0 edge.
- 16-bit words, left = 0xA5C3, right = 0x0F0F -> fifo_left_data = 0xA5C30000, fifo_right_data = 0x0F0F0000.
- 40-bit words (slot width exceeds register), left MSBs 0xFFFFFFFF plus 8 extra zero bits -> fifo_left_data = 0xFFFFFFFF.
- Enable asserted mid-right-word -> first partial RIGHT word dropped, first fifo_wr only after a complete left/right pair.
- fifo_full = 1 at frame end -> no fifo_wr, rx_overflow = 1 and held; i2s_enable low for 1 cycle -> rx_overflow = 0.
- wb_rst_i pulsed mid-left-word -> all outputs 0 next cycle, no fifo_wr until a full resync; i2s_ws_edge pulse count equals the number of ws transitions while enabled.

Source files
------------

// File: rtl/i2s_to_wb_rx.sv
// ---------------------------------------------------------------------------
// i2s_to_wb_rx
//
// Purpose:
//   Receives a stereo I2S stream whose bit clock is asynchronous to the
//   system clock. The stream is oversampled in the wb_clk_i domain, and each
//   complete left/right word pair is presented to a downstream FIFO with a
//   single write strobe. Words shorter than 32 bits are left-justified with
//   zero fill. Bits beyond the 32nd are discarded.
//
// Ports:
//   wb_clk_i         in   system clock; every flop uses its rising edge
//   wb_rst_i         in   synchronous, active-high reset
//   i2s_enable       in   receiver enable; low holds the receiver idle
//   i2s_sck_i        in   I2S bit clock (asynchronous, sampled as data)
//   i2s_ws_i         in   I2S word select, 0 = left, 1 = right (asynchronous)
//   i2s_sd_i         in   I2S serial data, MSB first (asynchronous)
//   fifo_left_data   out  left word of the last written frame
//   fifo_right_data  out  right word of the last written frame
//   fifo_wr          out  one-cycle write strobe covering both words
//   fifo_full        in   sink cannot accept a write
//   i2s_ws_edge      out  one-cycle pulse on every detected WS transition
//   rx_overflow      out  sticky: a frame was dropped because the sink was full
//
// wb_clk_i must run at least 4x the bit-clock frequency.
// ---------------------------------------------------------------------------
module i2s_to_wb_rx (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        i2s_enable,
  input  logic        i2s_sck_i,
  input  logic        i2s_ws_i,
  input  logic        i2s_sd_i,
  output logic [31:0] fifo_left_data,
  output logic [31:0] fifo_right_data,
  output logic        fifo_wr,
  input  logic        fifo_full,
  output logic        i2s_ws_edge,
  output logic        rx_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_LEFT  = 2'd2,
    ST_RIGHT = 2'd3
  } state_t;

  // Places one received bit at position (31 - cnt). Once 32 bits have been
  // taken the word is full and later bits leave it untouched.
  function automatic logic [31:0] insert_bit(input logic [31:0] word,
                                             input logic [5:0]  cnt,
                                             input logic        bit_val);
    logic [31:0] res;
    res = word;
    if (cnt < 6'd32) begin
      res[5'd31 - cnt[4:0]] = bit_val;
    end else begin
      res = word;
    end
    return res;
  endfunction

  // Synchronizer chains: two flops per input, plus one extra delay on sck
  // so a rising edge can be seen as (synchronized = 1, delayed = 0).
  logic [1:0]  sck_sync_q;
  logic        sck_dly_q;
  logic [1:0]  ws_sync_q;
  logic [1:0]  sd_sync_q;

  // Receiver state.
  state_t      state_q;
  logic        ws_prev_q;      // ws sampled at the previous sck rise
  logic [31:0] shift_q;        // word under assembly, filled from bit 31 down
  logic [5:0]  bit_cnt_q;      // bits taken so far, saturates at 32
  logic [31:0] left_word_q;    // committed left word awaiting its right partner
  logic        left_valid_q;

  // Registered outputs.
  logic [31:0] left_out_q;
  logic [31:0] right_out_q;
  logic        fifo_wr_q;
  logic        ws_edge_q;
  logic        overflow_q;

  // Combinational views of the current cycle.
  logic        sck_rise_s;
  logic        ws_smp_s;
  logic        sd_smp_s;
  logic        ws_trans_s;
  logic [31:0] word_d;         // shift register with this cycle's bit inserted

  assign sck_rise_s = sck_sync_q[1] & ~sck_dly_q;
  assign ws_smp_s   = ws_sync_q[1];
  assign sd_smp_s   = sd_sync_q[1];
  assign ws_trans_s = sck_rise_s & (ws_smp_s != ws_prev_q);
  assign word_d     = insert_bit(shift_q, bit_cnt_q, sd_smp_s);

  assign fifo_left_data  = left_out_q;
  assign fifo_right_data = right_out_q;
  assign fifo_wr         = fifo_wr_q;
  assign i2s_ws_edge     = ws_edge_q;
  assign rx_overflow     = overflow_q;

  // Bring the three I2S lines into the wb_clk_i domain.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sck_sync_q <= 2'b00;
      sck_dly_q  <= 1'b0;
      ws_sync_q  <= 2'b00;
      sd_sync_q  <= 2'b00;
    end else begin
      sck_sync_q <= {sck_sync_q[0], i2s_sck_i};
      sck_dly_q  <= sck_sync_q[1];
      ws_sync_q  <= {ws_sync_q[0], i2s_ws_i};
      sd_sync_q  <= {sd_sync_q[0], i2s_sd_i};
    end
  end

  // Receiver FSM: word assembly, commit on WS transitions, frame output.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      ws_prev_q    <= 1'b0;
      shift_q      <= 32'h0000_0000;
      bit_cnt_q    <= 6'd0;
      left_word_q  <= 32'h0000_0000;
      left_valid_q <= 1'b0;
      left_out_q   <= 32'h0000_0000;
      right_out_q  <= 32'h0000_0000;
      fifo_wr_q    <= 1'b0;
      ws_edge_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      fifo_wr_q <= 1'b0;
      ws_edge_q <= 1'b0;

      // The WS history follows every bit-clock rise, so the first
      // transition after enabling is judged against real line activity.
      if (sck_rise_s) begin
        ws_prev_q <= ws_smp_s;
      end

      if (!i2s_enable) begin
        // Disabling wins over anything in flight: the partial word and any
        // pending left word are dropped, the output words are held.
        state_q      <= ST_IDLE;
        shift_q      <= 32'h0000_0000;
        bit_cnt_q    <= 6'd0;
        left_valid_q <= 1'b0;
        overflow_q   <= 1'b0;
      end else begin
        if (ws_trans_s && (state_q != ST_IDLE)) begin
          ws_edge_q <= 1'b1;
        end

        case (state_q)
          ST_IDLE: begin
            state_q <= ST_SYNC;
          end

          ST_SYNC: begin
            // Wait for the start of a left word; the bit sampled here is the
            // tail of an unknown right word and is not kept.
            if (ws_trans_s && !ws_smp_s) begin
              state_q   <= ST_LEFT;
              shift_q   <= 32'h0000_0000;
              bit_cnt_q <= 6'd0;
            end
          end

          ST_LEFT: begin
            if (ws_trans_s) begin
              // One-bit delay: the bit taken at the transition closes the
              // left word.
              left_word_q  <= word_d;
              left_valid_q <= 1'b1;
              shift_q      <= 32'h0000_0000;
              bit_cnt_q    <= 6'd0;
              state_q      <= ST_RIGHT;
            end else if (sck_rise_s) begin
              shift_q <= word_d;
              if (bit_cnt_q < 6'd32) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
              end
            end
          end

          ST_RIGHT: begin
            if (ws_trans_s) begin
              // Frame end: the right word is complete in word_d.
              if (left_valid_q) begin
                if (!fifo_full) begin
                  left_out_q  <= left_word_q;
                  right_out_q <= word_d;
                  fifo_wr_q   <= 1'b1;
                end else begin
                  overflow_q <= 1'b1;
                end
              end
              left_valid_q <= 1'b0;
              shift_q      <= 32'h0000_0000;
              bit_cnt_q    <= 6'd0;
              state_q      <= ST_LEFT;
            end else if (sck_rise_s) begin
              shift_q <= word_d;
              if (bit_cnt_q < 6'd32) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
              end
            end
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_to_wb_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_to_wb_rx
//
// Drives an I2S stream (bit clock at 1/8 of wb_clk_i) into i2s_to_wb_rx.
// A reference model works on the bit stream as a whole: it collects the bits
// of each channel in a queue and turns them into a left-justified word when
// WS changes. Every frame the model expects to be written is queued together
// with the cycle at which the strobe must appear. A separate monitor pops and
// compares on every fifo_wr.
// ---------------------------------------------------------------------------
module tb_i2s_to_wb_rx;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sck;
  logic        ws;
  logic        sd;
  logic        full;
  logic [31:0] left_data;
  logic [31:0] right_data;
  logic        wr;
  logic        ws_edge;
  logic        ovf;

  i2s_to_wb_rx dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .i2s_enable      (en),
    .i2s_sck_i       (sck),
    .i2s_ws_i        (ws),
    .i2s_sd_i        (sd),
    .fifo_left_data  (left_data),
    .fifo_right_data (right_data),
    .fifo_wr         (wr),
    .fifo_full       (full),
    .i2s_ws_edge     (ws_edge),
    .rx_overflow     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  logic        m_bits[$];
  logic        m_en     = 1'b0;
  logic        m_synced = 1'b0;
  logic        m_prev_ws = 1'b0;
  logic        m_lv     = 1'b0;
  logic        m_ovf    = 1'b0;
  logic [31:0] m_left   = 32'h0;
  logic [31:0] m_out_l  = 32'h0;
  logic [31:0] m_out_r  = 32'h0;
  int          m_edges  = 0;
  int          dut_edges = 0;
  logic        cur_full = 1'b0;

  // First 32 received bits, MSB first, zero filled on the right.
  function automatic logic [31:0] pack_bits();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < m_bits.size() && i < 32; i++) w[31 - i] = m_bits[i];
    return w;
  endfunction

  task automatic m_rise(input logic ws_v, input logic sd_v, input logic full_v, input int now);
    logic        trans;
    logic [31:0] w;
    exp_t        e;
    trans = (ws_v != m_prev_ws);
    if (m_en) begin
      if (trans) m_edges++;
      if (!m_synced) begin
        if (trans && ws_v == 1'b0) begin
          m_synced = 1'b1;
          m_bits.delete();
        end
      end else begin
        m_bits.push_back(sd_v);
        if (trans) begin
          w = pack_bits();
          m_bits.delete();
          if (ws_v == 1'b1) begin
            m_left = w;
            m_lv   = 1'b1;
          end else if (m_lv) begin
            m_lv = 1'b0;
            if (full_v) begin
              m_ovf = 1'b1;
            end else begin
              e.l = m_left; e.r = w; e.at = now + 3;
              exp_q.push_back(e);
              m_out_l = m_left;
              m_out_r = w;
            end
          end
        end
      end
    end
    m_prev_ws = ws_v;
  endtask

  task automatic m_drop();
    m_synced = 1'b0;
    m_bits.delete();
    m_lv  = 1'b0;
    m_ovf = 1'b0;
  endtask

  // ------------------------------------------------------------------
  // Monitor
  // ------------------------------------------------------------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (ws_edge === 1'b1) dut_edges++;
    if (wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wr: got wr=1 expected no write (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_left", left_data, mon_e.l);
        chk("wr_right", right_data, mon_e.r);
        chk("wr_cycle", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  // One I2S bit: low phase with data set up, then a rise held for 4 cycles.
  task automatic send_bit(input logic ws_v, input logic sd_v);
    @(negedge clk);
    sck = 1'b0; ws = ws_v; sd = sd_v; full = cur_full;
    repeat (3) @(negedge clk);
    chk("hold_left", left_data, m_out_l);
    chk("hold_right", right_data, m_out_r);
    chk("overflow", {31'h0, ovf}, {31'h0, m_ovf});
    @(negedge clk);
    sck = 1'b1;
    m_rise(ws_v, sd_v, cur_full, cyc);
    repeat (3) @(negedge clk);
  endtask

  // One word of n bits on channel ch; the last bit carries the new WS.
  task automatic send_word(input logic ch, input logic [63:0] data, input int n, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      if (i == pulse_at) en_pulse();
      send_bit((i == n - 1) ? ~ch : ch, data[n - 1 - i]);
    end
  endtask

  task automatic en_pulse();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    m_drop();
  endtask

  task automatic do_reset_check();
    @(negedge clk);
    sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_left", left_data, 32'h0);
    chk("rst_right", right_data, 32'h0);
    chk("rst_wr", {31'h0, wr}, 32'h0);
    chk("rst_ws_edge", {31'h0, ws_edge}, 32'h0);
    chk("rst_overflow", {31'h0, ovf}, 32'h0);
    rst = 1'b0;
    m_drop();
    m_prev_ws = 1'b0;
    m_out_l = 32'h0;
    m_out_r = 32'h0;
  endtask

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  initial begin
    logic [63:0] rnd;
    int          n;
    rst = 1'b1; en = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0; full = 1'b0;
    repeat (4) @(negedge clk);
    do_reset_check();

    // Receiver disabled: traffic is ignored; enable arrives mid-right-word.
    send_word(1'b0, 64'h5A, 8, -1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'($urandom));
    @(negedge clk);
    en = 1'b1;
    m_en = 1'b1;
    send_word(1'b1, 64'h3FF, 10, -1);

    // Full 32-bit frame.
    cur_full = 1'b0;
    send_word(1'b0, 64'h1234_5678, 32, -1);
    send_word(1'b1, 64'h9ABC_DEF0, 32, -1);
    repeat (4) @(negedge clk);
    chk("frame32_left", left_data, 32'h1234_5678);
    chk("frame32_right", right_data, 32'h9ABC_DEF0);

    // 16-bit words are left-justified.
    send_word(1'b0, 64'hA5C3, 16, -1);
    send_word(1'b1, 64'h0F0F, 16, -1);
    repeat (4) @(negedge clk);
    chk("frame16_left", left_data, 32'hA5C3_0000);
    chk("frame16_right", right_data, 32'h0F0F_0000);

    // 40-bit slots: extra bits are discarded.
    send_word(1'b0, 64'hFF_FFFF_FF00, 40, -1);
    send_word(1'b1, 64'h12_3456_7899, 40, -1);
    repeat (4) @(negedge clk);
    chk("frame40_left", left_data, 32'hFFFF_FFFF);
    chk("frame40_right", right_data, 32'h1234_5678);

    // Sink full at frame end: dropped, overflow set and sticky.
    cur_full = 1'b1;
    send_word(1'b0, 64'hDEAD_BEEF, 32, -1);
    send_word(1'b1, 64'hCAFE_F00D, 32, -1);
    cur_full = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovf_set", {31'h0, ovf}, 32'h1);
    chk("ovf_left_held", left_data, 32'hFFFF_FFFF);
    send_word(1'b0, 64'h1111_2222, 32, -1);
    send_word(1'b1, 64'h3333_4444, 32, -1);
    repeat (4) @(negedge clk);
    chk("ovf_sticky", {31'h0, ovf}, 32'h1);

    // One-cycle disable mid-left-word clears overflow and forces a resync.
    send_word(1'b0, 64'h5555_AAAA, 32, 12);
    repeat (2) @(negedge clk);
    chk("ovf_cleared", {31'h0, ovf}, 32'h0);
    send_word(1'b1, 64'h7777_8888, 32, -1);
    send_word(1'b0, 64'h0BAD_F00D, 32, -1);
    send_word(1'b1, 64'h600D_CAFE, 32, -1);

    // Reset in the middle of a left word.
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom));
    do_reset_check();
    send_word(1'b0, 64'h0000_FFFF, 22, -1);
    send_word(1'b1, 64'h1357_9BDF, 32, -1);
    send_word(1'b0, 64'h2468_ACE0, 32, -1);
    send_word(1'b1, 64'hFEDC_BA98, 32, -1);

    // Randomised frames: widths 12..40, occasional full sink or disable pulse.
    for (int f = 0; f < 24; f++) begin
      n = $urandom_range(40, 12);
      cur_full = ($urandom_range(3, 0) == 0);
      rnd = {$urandom, $urandom};
      send_word(1'b0, rnd, n, ($urandom_range(7, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1);
      rnd = {$urandom, $urandom};
      send_word(1'b1, rnd, n, -1);
    end
    cur_full = 1'b0;

    repeat (12) @(negedge clk);
    chk("pending_writes", 32'(exp_q.size()), 32'h0);
    chk("ws_edge_count", 32'(dut_edges), 32'(m_edges));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
